// File: rtl/wb_regfile_unit.sv
// Writeback-stage register file: selects the writeback value, writes the
// 4 x DATA_W register file, serves two bypassed decode read ports plus a
// bypassed stack-pointer view, and owns the registered OUT_PORT latch.
module wb_regfile_unit #(
   parameter int                 DATA_W   = 8,
   parameter int                 SP_IDX   = 3,
   parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(8'hFF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_regf_W,
   input  logic [1:0]        mux_rdata_sel_W,
   input  logic [1:0]        ADDER_W,
   input  logic [DATA_W-1:0] alu_out_W,
   input  logic [DATA_W-1:0] read_data_W,
   input  logic [DATA_W-1:0] IN_PORT_W,
   input  logic [DATA_W-1:0] RD2_W,
   input  logic              out_port_sel_W,
   input  logic              sp_wr_en,
   input  logic [DATA_W-1:0] sp_next,
   input  logic [1:0]        ra1,
   input  logic [1:0]        ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] sp_out,
   output logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] OUT_PORT,
   output logic              out_strobe
);

   localparam logic [1:0] SP_ADDR = 2'(SP_IDX);

   logic [DATA_W-1:0] regs [4];

   // Writeback data select; also forwarded upstream as wb_data.
   always_comb begin
      // NOTE: every combinational output gets a value on every path (the
      // default arm here) so no latch is inferred.
      unique case (mux_rdata_sel_W)
         2'b00:   wb_data = alu_out_W;
         2'b01:   wb_data = read_data_W;
         2'b10:   wb_data = IN_PORT_W;
         default: wb_data = RD2_W;
      endcase
   end

   // Register array update: writeback has priority over the SP port on the
   // SP entry; writes to different entries both land.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the array is only four entries of architectural state, so it
         // is reset explicitly (SP entry to its own value) rather than left
         // as an uninitialised memory.
         for (int i = 0; i < 4; i++) begin
            regs[i] <= (2'(i) == SP_ADDR) ? SP_RESET : '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            // NOTE: non-blocking assignments keep every entry sampling the
            // pre-edge inputs, independent of statement order.
            if (wr_en_regf_W && ADDER_W == 2'(i)) begin
               regs[i] <= wb_data;
            end else if (sp_wr_en && SP_ADDR == 2'(i)) begin
               regs[i] <= sp_next;
            end
         end
      end
   end

   // Write-first read: pending writeback, then pending SP update, then array.
   function automatic logic [DATA_W-1:0] bypass_read(input logic [1:0] addr);
      if (wr_en_regf_W && ADDER_W == addr) begin
         return wb_data;
      end else if (sp_wr_en && addr == SP_ADDR) begin
         return sp_next;
      end
      return regs[addr];
   endfunction

   // Decode-side read ports and stack-pointer view.
   always_comb begin
      rd1    = bypass_read(ra1);
      rd2    = bypass_read(ra2);
      sp_out = bypass_read(SP_ADDR);
   end

   // OUT_PORT latch with a one-cycle strobe per OUT instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         OUT_PORT   <= '0;
         out_strobe <= 1'b0;
      end else begin
         out_strobe <= out_port_sel_W;
         if (out_port_sel_W) begin
            OUT_PORT <= RD2_W;
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Scoreboard bench for wb_regfile_unit: stimulus pushes cycle-tagged
// expectations, a negedge monitor pops and compares them; a strobe monitor
// checks OUT_PORT against a separate queue whenever out_strobe is high.
module tb_wb_regfile_unit;

   typedef enum int {S_RD1, S_RD2, S_SP, S_WB, S_OUT, S_STB} sig_e;

   typedef struct {
      int         cyc;
      sig_e       sig;
      logic [7:0] exp;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en_regf_W = 1'b0;
   logic [1:0] mux_rdata_sel_W = '0;
   logic [1:0] ADDER_W = '0;
   logic [7:0] alu_out_W = '0;
   logic [7:0] read_data_W = '0;
   logic [7:0] IN_PORT_W = '0;
   logic [7:0] RD2_W = '0;
   logic       out_port_sel_W = 1'b0;
   logic       sp_wr_en = 1'b0;
   logic [7:0] sp_next = '0;
   logic [1:0] ra1 = '0;
   logic [1:0] ra2 = '0;
   logic [7:0] rd1, rd2, sp_out, wb_data, OUT_PORT;
   logic       out_strobe;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t out_q[$];

   wb_regfile_unit dut (
      .clk(clk), .reset(reset), .wr_en_regf_W(wr_en_regf_W),
      .mux_rdata_sel_W(mux_rdata_sel_W), .ADDER_W(ADDER_W),
      .alu_out_W(alu_out_W), .read_data_W(read_data_W), .IN_PORT_W(IN_PORT_W),
      .RD2_W(RD2_W), .out_port_sel_W(out_port_sel_W), .sp_wr_en(sp_wr_en),
      .sp_next(sp_next), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .sp_out(sp_out), .wb_data(wb_data), .OUT_PORT(OUT_PORT),
      .out_strobe(out_strobe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] get_sig(input sig_e s);
      case (s)
         S_RD1:   return rd1;
         S_RD2:   return rd2;
         S_SP:    return sp_out;
         S_WB:    return wb_data;
         S_OUT:   return OUT_PORT;
         default: return {7'b0, out_strobe};
      endcase
   endfunction

   // Expectation for the current cycle (offset 0) or a later one.
   task automatic expect_at(input int ofs, input sig_e s, input logic [7:0] v, input string n);
      exp_t e;
      e.cyc = cyc + ofs; e.sig = s; e.exp = v; e.name = n;
      sb_q.push_back(e);
   endtask

   task automatic expect_out(input logic [7:0] v, input string n);
      exp_t e;
      e.cyc = cyc + 1; e.sig = S_OUT; e.exp = v; e.name = n;
      out_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compares everything due this cycle, flags stale items.
   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            check(sb_q[i].name, get_sig(sb_q[i].sig), sb_q[i].exp);
            sb_q.delete(i);
         end else if (sb_q[i].cyc < cyc) begin
            check({sb_q[i].name, "_missed"}, 8'h00, 8'h01);
            sb_q.delete(i);
         end
      end
   end

   // Output-port monitor: each strobe must match the next queued OUT value.
   always @(negedge clk) begin
      if (reset && out_strobe === 1'b1) begin
         if (out_q.size() == 0) begin
            check("unexpected_strobe", OUT_PORT, 8'hxx);
         end else begin
            check(out_q[0].name, OUT_PORT, out_q[0].exp);
            check({out_q[0].name, "_when"}, 8'(cyc - out_q[0].cyc), 8'h00);
            void'(out_q.pop_front());
         end
      end
   end

   initial begin
      // Reset state
      tick(); tick();
      ra1 = 2'd0; ra2 = 2'd2;
      expect_at(0, S_RD1, 8'h00, "rst_r0");
      expect_at(0, S_RD2, 8'h00, "rst_r2");
      expect_at(0, S_SP,  8'hFF, "rst_sp");
      expect_at(0, S_OUT, 8'h00, "rst_out");
      expect_at(0, S_STB, 8'h00, "rst_stb");
      tick();
      reset = 1'b1;
      ra2 = 2'd1;
      expect_at(0, S_RD2, 8'h00, "rst_r1");
      tick();

      // Reset asserted in the middle of a write to R1
      wr_en_regf_W = 1'b1; ADDER_W = 2'd1; alu_out_W = 8'h55; reset = 1'b0;
      tick(); tick();
      reset = 1'b1; wr_en_regf_W = 1'b0; ra1 = 2'd1;
      tick();
      expect_at(0, S_RD1, 8'h00, "midwrite_r1");
      tick();

      // Write R2 with same-cycle bypass, then array read
      wr_en_regf_W = 1'b1; ADDER_W = 2'd2; mux_rdata_sel_W = 2'b00;
      alu_out_W = 8'h3C; ra1 = 2'd2;
      expect_at(0, S_RD1, 8'h3C, "bypass_r2");
      expect_at(0, S_WB,  8'h3C, "wb_alu");
      tick();
      wr_en_regf_W = 1'b0;
      expect_at(0, S_RD1, 8'h3C, "array_r2");
      tick();

      // Mux sweep into R1
      read_data_W = 8'h11; IN_PORT_W = 8'h22; RD2_W = 8'h33;
      wr_en_regf_W = 1'b1; ADDER_W = 2'd1; ra2 = 2'd1;
      mux_rdata_sel_W = 2'b01;
      expect_at(0, S_WB,  8'h11, "wb_mem");
      expect_at(0, S_RD2, 8'h11, "bypass_mem");
      tick();
      mux_rdata_sel_W = 2'b10;
      expect_at(0, S_WB,  8'h22, "wb_in");
      expect_at(0, S_RD2, 8'h22, "bypass_in");
      tick();
      mux_rdata_sel_W = 2'b11;
      expect_at(0, S_WB,  8'h33, "wb_rd2");
      expect_at(0, S_RD2, 8'h33, "bypass_rd2");
      tick();
      wr_en_regf_W = 1'b0; mux_rdata_sel_W = 2'b00; ra1 = 2'd1;
      expect_at(0, S_RD1, 8'h33, "array_r1");
      expect_at(0, S_RD2, 8'h33, "array_r1_p2");
      tick();

      // SP port alone
      sp_wr_en = 1'b1; sp_next = 8'hFE; ra1 = 2'd3;
      expect_at(0, S_SP,  8'hFE, "sp_bypass");
      expect_at(0, S_RD1, 8'hFE, "sp_rd1_bypass");
      tick();
      sp_wr_en = 1'b0;
      expect_at(0, S_SP, 8'hFE, "sp_array");
      tick();

      // Writeback to SP index collides with sp_wr_en: writeback wins
      sp_wr_en = 1'b1; sp_next = 8'hFD;
      wr_en_regf_W = 1'b1; ADDER_W = 2'd3; alu_out_W = 8'h80;
      expect_at(0, S_RD1, 8'h80, "collide_rd1");
      expect_at(0, S_SP,  8'h80, "collide_sp");
      tick();
      sp_wr_en = 1'b0; wr_en_regf_W = 1'b0;
      expect_at(0, S_SP, 8'h80, "collide_array");
      tick();

      // SP update plus write to another index: both land
      sp_wr_en = 1'b1; sp_next = 8'h40;
      wr_en_regf_W = 1'b1; ADDER_W = 2'd0; alu_out_W = 8'h99;
      tick();
      sp_wr_en = 1'b0; wr_en_regf_W = 1'b0; ra1 = 2'd0;
      expect_at(0, S_SP,  8'h40, "dual_sp");
      expect_at(0, S_RD1, 8'h99, "dual_r0");
      tick();

      // Back-to-back OUTs, then hold
      out_port_sel_W = 1'b1; RD2_W = 8'hA5;
      expect_out(8'hA5, "out_first");
      expect_at(1, S_STB, 8'h01, "stb_first");
      tick();
      RD2_W = 8'h5A;
      expect_out(8'h5A, "out_second");
      expect_at(1, S_STB, 8'h01, "stb_second");
      tick();
      out_port_sel_W = 1'b0; RD2_W = 8'h77;
      expect_at(1, S_STB, 8'h00, "stb_low");
      expect_at(1, S_OUT, 8'h5A, "out_hold");
      tick();

      // Disabled write with matching address: no bypass, no write
      wr_en_regf_W = 1'b0; ADDER_W = 2'd0; ra1 = 2'd0; alu_out_W = 8'hFF;
      expect_at(0, S_RD1, 8'h99, "nowr_rd1");
      expect_at(0, S_WB,  8'hFF, "nowr_wb");
      tick();
      expect_at(0, S_RD1, 8'h99, "nowr_array");
      tick(); tick();

      if (sb_q.size() != 0) check("sb_leftover", 8'(sb_q.size()), 8'h00);
      if (out_q.size() != 0) check("out_leftover", 8'(out_q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. It selects the writeback data and writes it into a 4-entry x 8-bit register file. It serves two decode-stage read ports with write-first bypass, and holds a dedicated stack-pointer update port plus the registered OUT_PORT latch. The block sits between the MEM/WB register outputs and the decode stage.

Parameters:
DATA_W, 8, data width of registers, buses and output port
SP_IDX, 3, register index used as stack pointer
SP_RESET, 8'hFF, reset value of R[SP_IDX]

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
wr_en_regf_W  in  1  register-file write enable from writeback
mux_rdata_sel_W  in  2  writeback data select
ADDER_W  in  2  destination register index
alu_out_W  in  DATA_W  ALU result
read_data_W  in  DATA_W  memory read data
IN_PORT_W  in  DATA_W  input-port sample
RD2_W  in  DATA_W  register data 2 carried down the pipe
out_port_sel_W  in  1  OUT instruction in writeback
sp_wr_en  in  1  stack-pointer update request from decode (PUSH/POP)
sp_next  in  DATA_W  new stack-pointer value
ra1, ra2  in  2  decode read addresses
rd1, rd2  out  DATA_W  decode read data (bypassed)
sp_out  out  DATA_W  current R[SP_IDX] (bypassed)
wb_data  out  DATA_W  selected writeback value, combinational, for forwarding
OUT_PORT  out  DATA_W  registered output port
out_strobe  out  1  one-cycle pulse when OUT_PORT updates

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-write):
  - R0..R2 = 0, R[SP_IDX] = SP_RESET.
  - OUT_PORT = 0, out_strobe = 0.
  - A reset deassertion never triggers a write on the same edge.
- wb_data mux (combinational): 00 alu_out_W, 01 read_data_W, 10 IN_PORT_W, 11 RD2_W.
- Register write:
  - On a rising edge with wr_en_regf_W=1, R[ADDER_W] <= wb_data.
  - No write when wr_en_regf_W=0, regardless of other inputs.
- SP port: on a rising edge with sp_wr_en=1, R[SP_IDX] <= sp_next.
- Simultaneous writeback to SP_IDX and sp_wr_en: the writeback wins and sp_next is dropped. Writes to other indices and sp_wr_en both take effect.
- Reads are combinational, write-first bypass:
  - rdN = wb_data if wr_en_regf_W=1 and ADDER_W==raN.
  - Otherwise, if raN==SP_IDX and sp_wr_en=1, rdN = sp_next.
  - Otherwise rdN = R[raN].
  - sp_out follows the same priority for index SP_IDX.
- Output port:
  - On a rising edge with out_port_sel_W=1, OUT_PORT <= RD2_W and out_strobe <= 1.
  - Otherwise OUT_PORT holds and out_strobe <= 0.
  - Back-to-back OUTs produce a strobe on every cycle with updated data.
- Latency:
  - A write is visible to decode in the same cycle through bypass and from the array one cycle later.
  - OUT_PORT is one cycle after out_port_sel_W is sampled high.
- Arithmetic: none. sp_next wrap (0x00 to 0xFF) is computed upstream and is stored unchanged.
- X-safety: unselected inputs never affect state.

Test Plan:
- Reset -> R0..R2=0, sp_out=0xFF, OUT_PORT=0, out_strobe=0. Assert reset mid-write (wr_en=1, ADDER_W=1, alu_out_W=0x55) -> R1 stays 0.
- wr_en=1, ADDER_W=2, sel=00, alu_out_W=0x3C, ra1=2 -> rd1=0x3C in the same cycle. Next cycle with wr_en=0 -> rd1=0x3C from the array.
- Mux sweep to R1 with read_data_W=0x11, IN_PORT_W=0x22, RD2_W=0x33 on sel=01/10/11 -> R1 = 0x11, 0x22, 0x33 on consecutive cycles.
- sp_wr_en=1, sp_next=0xFE alone -> sp_out=0xFE. Then sp_wr_en=1, sp_next=0xFD with wr_en=1, ADDER_W=3, alu_out_W=0x80 -> R3=0x80 and rd (ra=3) bypass shows 0x80.
- out_port_sel_W=1 for two cycles with RD2_W=0xA5 then 0x5A -> OUT_PORT=0xA5 then 0x5A, out_strobe high both cycles, then low with OUT_PORT holding 0x5A.
- wr_en=0, ADDER_W=ra1=0, alu_out_W=0xFF -> rd1 shows the stored R0 value, with no bypass and no write.
